// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and port indices.
package dmem_arb_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage : dmem_arb_defs

// File: rtl/dmem_arbiter_arb.sv
// Two-port round-robin arbiter with bounded burst lock; purely combinational.
module rr_arb2
    import dmem_arb_defs::*;
#(
    parameter int MAX_BURST = 4,
    parameter int BW        = 2
) (
    input  logic [1:0]    req,
    input  logic          prio,
    input  logic [1:0]    lock,
    input  logic [BW-1:0] burst_cnt,
    output logic          gnt_idx,
    output logic          next_prio,
    output logic [BW-1:0] next_burst
);

    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    logic other_req_s;

    // Winner: a lone requester wins, a tie goes to the port holding priority.
    always_comb begin
        gnt_idx = prio;
        case (req)
            2'b01:   gnt_idx = PORT0;
            2'b10:   gnt_idx = PORT1;
            default: gnt_idx = prio;
        endcase
    end

    // Priority hand-over: a locked winner keeps priority for a bounded burst only while contended.
    always_comb begin
        next_prio   = prio;
        next_burst  = burst_cnt;
        other_req_s = (gnt_idx == PORT0) ? req[1] : req[0];
        if (!other_req_s) begin
            next_prio  = gnt_idx;
            next_burst = {BW{1'b0}};
        end else if (lock[gnt_idx] && (burst_cnt < BURST_LAST)) begin
            next_prio  = gnt_idx;
            next_burst = burst_cnt + BW'(1);
        end else begin
            next_prio  = ~gnt_idx;
            next_burst = {BW{1'b0}};
        end
    end

endmodule : rr_arb2

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (port 0) and the debug loader (port 1).
// One access every three cycles: IDLE (arbitrate) -> ACCESS (memory cycle) -> RESP (ack pulse).
module dmem_arbiter
    import dmem_arb_defs::*;
#(
    parameter int n_bits    = 32,
    parameter int DEPTH     = 256,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [n_bits-1:0] addr0,
    input  logic [n_bits-1:0] addr1,
    input  logic [n_bits-1:0] wdata0,
    input  logic [n_bits-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [n_bits-1:0] mem_rd,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [n_bits-1:0] rdata,
    output logic [n_bits-1:0] mem_a,
    output logic [n_bits-1:0] mem_wd,
    output logic              mem_we,
    output logic              busy
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [n_bits-1:0] DEPTH_W = n_bits'(DEPTH);

    state_t            state_r;
    state_t            state_next_s;
    logic              grant_s;
    logic              sel_r;
    logic              we_r;
    logic              in_range_r;
    logic              prio_r;
    logic [BW-1:0]     burst_cnt_r;
    logic              gnt_idx_s;
    logic              next_prio_s;
    logic [BW-1:0]     next_burst_s;
    logic [n_bits-1:0] win_addr_s;
    logic [n_bits-1:0] win_wdata_s;
    logic              win_we_s;
    logic              win_in_range_s;

    rr_arb2 #(
        .MAX_BURST (MAX_BURST),
        .BW        (BW)
    ) u_arb (
        .req        ({req1, req0}),
        .prio       (prio_r),
        .lock       ({lock1, lock0}),
        .burst_cnt  (burst_cnt_r),
        .gnt_idx    (gnt_idx_s),
        .next_prio  (next_prio_s),
        .next_burst (next_burst_s)
    );

    // Route the winning port's request fields and range-check its address.
    always_comb begin
        if (gnt_idx_s == PORT1) begin
            win_addr_s  = addr1;
            win_wdata_s = wdata1;
            win_we_s    = we1;
        end else begin
            win_addr_s  = addr0;
            win_wdata_s = wdata0;
            win_we_s    = we0;
        end
        win_in_range_s = (win_addr_s < DEPTH_W);
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    state_next_s = ACCESS;
                    grant_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS:  state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, arbitration bookkeeping and all registered memory/requester outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            sel_r       <= PORT0;
            we_r        <= 1'b0;
            in_range_r  <= 1'b0;
            prio_r      <= PORT0;
            burst_cnt_r <= {BW{1'b0}};
            mem_a       <= {n_bits{1'b0}};
            mem_wd      <= {n_bits{1'b0}};
            mem_we      <= 1'b0;
            rdata       <= {n_bits{1'b0}};
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s != IDLE);
            mem_we  <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            if (grant_s) begin
                sel_r       <= gnt_idx_s;
                mem_a       <= win_addr_s;
                mem_wd      <= win_wdata_s;
                we_r        <= win_we_s;
                in_range_r  <= win_in_range_s;
                // Out-of-range writes never reach the memory.
                mem_we      <= win_we_s & win_in_range_s;
                prio_r      <= next_prio_s;
                burst_cnt_r <= next_burst_s;
            end
            if (state_r == ACCESS) begin
                // Only in-range reads return memory data; writes and errors return zero.
                rdata <= (in_range_r && !we_r) ? mem_rd : {n_bits{1'b0}};
                ack0  <= (sel_r == PORT0);
                ack1  <= (sel_r == PORT1);
                err0  <= (sel_r == PORT0) && !in_range_r;
                err1  <= (sel_r == PORT1) && !in_range_r;
            end
        end
    end

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-word memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1, mem_rd;
    logic        ack0, ack1, err0, err1, mem_we, busy;
    logic [31:0] rdata, mem_a, mem_wd;
    logic [31:0] mem [0:255];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1), .mem_rd(mem_rd),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .busy(busy)
    );

    // Memory model: asynchronous read, write on the clock edge while WE is high.
    always @(posedge clk) begin
        if (mem_we === 1'b1 && mem_a < 32'd256) mem[mem_a[7:0]] <= mem_wd;
    end
    assign mem_rd = (mem_a < 32'd256) ? mem[mem_a[7:0]] : 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Checks an ack from the expected port with the expected read data.
    task automatic expect_grant(input logic port, input logic [31:0] exp_rd, input string tag);
        check1({tag, "_ack0"}, ack0, !port);
        check1({tag, "_ack1"}, ack1, port);
        check({tag, "_rdata"}, rdata, exp_rd);
    endtask

    // One isolated access from IDLE: drive, check ACCESS cycle, check RESP cycle, back to IDLE.
    task automatic single(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_err, input string tag);
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
        tick();
        check1({tag, "_mem_we"}, mem_we, we & !exp_err);
        check1({tag, "_ack_early"}, ack0 | ack1, 1'b0);
        check({tag, "_mem_a"}, mem_a, addr);
        tick();
        expect_grant(port, exp_rd, tag);
        check1({tag, "_err"}, port ? err1 : err0, exp_err);
        check1({tag, "_mem_we_resp"}, mem_we, 1'b0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check1({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [5:0] seq;
        logic [7:0] ack_pat;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;

        // Reset values
        tick();
        tick();
        check1("rst_busy", busy, 1'b0);
        check1("rst_ack", ack0 | ack1, 1'b0);
        check1("rst_err", err0 | err1, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;

        // Single write then read, plus preload used by later tests
        single(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0, "wr5");
        check("mem5", mem[5], 32'hDEADBEEF);
        single(1'b0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, "rd5");
        single(1'b1, 1'b1, 32'd0, 32'h0000CAFE, 32'd0, 1'b0, "wr0_p1");
        single(1'b0, 1'b1, 32'd10, 32'h00001010, 32'd0, 1'b0, "wr10");
        single(1'b1, 1'b1, 32'd11, 32'h00001111, 32'd0, 1'b0, "wr11");
        single(1'b1, 1'b0, 32'd11, 32'd0, 32'h00001111, 1'b0, "rd11_p1");

        // Out-of-range write and the last in-range/first out-of-range reads
        single(1'b0, 1'b1, 32'd256, 32'h12345678, 32'd0, 1'b1, "oor_wr");
        check("mem0_kept", mem[0], 32'h0000CAFE);
        single(1'b0, 1'b0, 32'd255, 32'd0, mem[255], 1'b0, "rd255");
        single(1'b1, 1'b0, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, "oor_rd_max");

        // Simultaneous requests after reset: strict alternation starting with port 0
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd11;
        seq = 6'b001010;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_grant(seq[i], seq[i] ? 32'h00001111 : 32'h00001010, $sformatf("alt%0d", i));
            if (i < 3) begin
                tick();
                tick();
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Locked burst from port 1: 0, then four port-1 grants, then port 0
        do_reset();
        lock1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        seq = 6'b011110;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_grant(seq[i], seq[i] ? 32'h00001111 : 32'h00001010, $sformatf("lock%0d", i));
            if (i < 5) begin
                tick();
                tick();
            end
        end
        // Burst counter restarted: port 1 gets the next grant and may burst again
        tick();
        tick();
        tick();
        expect_grant(1'b1, 32'h00001111, "lock6");
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        tick();

        // Held request across ack: acks spaced three cycles apart
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd10;
        ack_pat = 8'b10010010;
        for (int i = 0; i < 8; i++) begin
            tick();
            check1($sformatf("held_ack0_%0d", i), ack0, ack_pat[i]);
            check1($sformatf("held_ack1_%0d", i), ack1, 1'b0);
        end
        req0 = 1'b0;
        tick();

        // Reset on the edge that ends an ACCESS write
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd20; wdata0 = 32'h55AA55AA;
        tick();
        check1("rstw_mem_we", mem_we, 1'b1);
        rst_n = 1'b0;
        tick();
        req0 = 1'b0; we0 = 1'b0;
        check("rstw_commit", mem[20], 32'h55AA55AA);
        check1("rstw_ack", ack0, 1'b0);
        check1("rstw_busy", busy, 1'b0);
        check1("rstw_mem_we_off", mem_we, 1'b0);
        check("rstw_mem_a", mem_a, 32'd0);
        check("rstw_mem_wd", mem_wd, 32'd0);
        rst_n = 1'b1;
        tick();
        check1("rstw_no_late_ack", ack0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_dmem_arbiter

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and access sequencer that shares the single-port data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/program loader). It performs round-robin arbitration with an optional bounded burst lock and range-checks every address. It drives the memory's address, write-data and write-enable inputs from registers and returns read data with a one-cycle acknowledge. It sits between the requesters and `data_memory`, which is the only block allowed to drive that memory.

## Interface
- `n_bits`, 32, data and address width.
- `DEPTH`, 256, number of valid memory words; addresses ≥ DEPTH are errors.
- `MAX_BURST`, 4, maximum consecutive grants to one locked port while the other port is requesting.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on posedge `clk`.
- `req0` / `req1`  in  1  access request; held until the matching `ack`.
- `we0` / `we1`  in  1  1 = write, 0 = read; stable while `req` is high.
- `addr0` / `addr1`  in  n_bits  word address; stable while `req` is high.
- `wdata0` / `wdata1`  in  n_bits  write data; stable while `req` is high.
- `lock0` / `lock1`  in  1  request to keep priority for the next arbitration.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `err0` / `err1`  out  1  valid with `ack`: address out of range.
- `rdata`  out  n_bits  read data, valid in the `ack` cycle.
- `mem_a`  out  n_bits  to memory `A`.
- `mem_wd`  out  n_bits  to memory `WD`.
- `mem_we`  out  1  to memory `WE`.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- **IDLE**
  - If no `req` is high, remain in IDLE.
  - Otherwise pick the winner, then register `sel`, `mem_a`, `mem_wd` and the `we` value.
  - Go to ACCESS.
- **Winner selection**
  - If exactly one port requests, that port wins.
  - If both request, the port holding priority `prio` wins.
- **ACCESS**
  - `mem_we` = registered `we` AND address in range.
  - For a read, capture `RD` into `rdata` at the end of the cycle.
  - For a write, `rdata` is set to 0.
  - For an out-of-range address, `mem_we` = 0, `rdata` = 0 and `err` is set.
  - Go to RESP.
- **RESP**
  - `ack` and `err` of `sel` are high for exactly one cycle.
  - Go to IDLE.
  - `req` lines are not sampled in RESP. A requester keeping `req` high after `ack` is treated as a new request in the following IDLE cycle.
- **Priority update** (applied on the IDLE→ACCESS transition)
  - If the winner has `lock` high, the other port is requesting, and `burst_cnt` < MAX_BURST−1: `prio` stays on the winner and `burst_cnt` increments.
  - Otherwise `prio` moves to the other port and `burst_cnt` is cleared.
  - If the other port is not requesting, `burst_cnt` is cleared and `prio` stays on the winner.
- **Width rules**
  - `burst_cnt` is `$clog2(MAX_BURST)` bits wide.
  - The range check is an unsigned compare `addr < DEPTH`.

## Timing
- Reset values: state IDLE, `prio` = port 0, `burst_cnt` = 0, all outputs 0 (including `mem_a`, `mem_wd` and `rdata`).
- Latency for a request first seen high in IDLE at cycle N:
  - ACCESS occurs at N+1.
  - For a write, memory commits at the N+1→N+2 edge.
  - `ack` and `rdata` are valid at N+2.
- Throughput is one access per 3 cycles.
- Outside ACCESS, `mem_we` = 0 and `mem_a` / `mem_wd` hold their last values.
- Simultaneous requests: resolved by `prio`. The loser's request stays pending and is served in the next IDLE cycle unless a locked burst continues.
- Starvation bound: a requesting port waits at most MAX_BURST grants to the other port.
- Reset mid-operation:
  - A write in ACCESS whose final edge coincides with `rst_n` low still commits, because `mem_we` was already high at that edge.
  - No `ack` is issued for that access.
  - A transaction reset in RESP loses its `ack`.
- Requests dropped before `ack` are a protocol violation; behaviour is unspecified, but the FSM must still return to IDLE.

## Structure
- Shared header/package `dmem_arb_defs`:
  - state encodings IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  - port indices PORT0 = 1'b0, PORT1 = 1'b1.
- Sub-module `rr_arb2`, purely combinational:
  - inputs: `req[1:0]`, `prio`, `lock`, `burst_cnt`;
  - outputs: `gnt_idx`, `next_prio`, `next_burst`.
- The FSM, registers and range check live in `dmem_arbiter`.

## Test plan
- **Single write then read:** write `addr0` = 5, `wdata0` = 0xDEADBEEF, then read `addr0` = 5. Expect `mem_we` high in cycle N+1 only, `ack0` at N+2, and the read returns `rdata` = 0xDEADBEEF with `err0` = 0.
- **Simultaneous requests after reset:** `req0` and `req1` both high, no lock. Expect port 0 served first, then port 1, then port 0 again, strictly alternating.
- **Locked burst:** `lock1` = 1 with both ports continuously requesting, MAX_BURST = 4. Expect 4 port-1 grants followed by 1 port-0 grant, and `burst_cnt` cleared.
- **Out of range:** `addr0` = 256 write. Expect `mem_we` to stay 0, `ack0` = 1 with `err0` = 1, `rdata` = 0, and memory word 0 unchanged.
- **Reset during ACCESS write:** `rst_n` low for the edge ending ACCESS. Expect the write to commit, no `ack`, and all outputs 0 with state IDLE on the next cycle.
- **Held `req` across `ack`:** keep `req0` high after `ack0`. Expect no sampling in RESP and the next access to start from IDLE, giving 3-cycle spacing between acks.
